// File: rtl/div_pkg_6.sv
// Shared types and default widths for the sequential restoring divider.
// Included by the divider top and its datapath step.
package div_pkg_6;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIVIDEND_W-1:0] QUOT_DBZ = '1;
endpackage

// File: rtl/div_step_6.sv
// One restoring shift-subtract step.
// Reusable as a stage of an unrolled divider.
module div_step_6 #(
  parameter int W = div_pkg_6::DIVISOR_W
) (
  input  logic [W-1:0] pr,
  input  logic         next_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] pr_next,
  output logic         q_bit
);
  logic [W:0]   w_t;
  logic [W-1:0] w_diff;

  assign w_t    = {pr, next_bit};
  // difference is below divisor when taken, so W bits suffice
  assign w_diff = w_t[W-1:0] - divisor;
  assign q_bit  = (w_t >= {1'b0, divisor});
  assign pr_next = q_bit ? w_diff : w_t[W-1:0];
endmodule

// File: rtl/div_seq_6.sv
// Iterative unsigned divider: one quotient bit per clock.
// Start/busy/rdy handshake; results held until the next start.
module div_seq_6 #(
  parameter int DIVIDEND_W = div_pkg_6::DIVIDEND_W,
  parameter int DIVISOR_W  = div_pkg_6::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  rdy,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  import div_pkg_6::*;

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W-1:0]  r_pr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dbz;
  logic                  r_wait;
  logic                  r_rdy;
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_dbz_o;

  logic [DIVISOR_W-1:0]  w_pr_next;
  logic                  w_q_bit;

  div_step_6 #(
    .W(DIVISOR_W)
  ) u_step (
    .pr      (r_pr),
    .next_bit(r_dvd[DIVIDEND_W-1]),
    .divisor (r_dvs),
    .pr_next (w_pr_next),
    .q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_q     <= '0;
      r_dvs   <= '0;
      r_pr    <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
      r_wait  <= 1'b0;
      r_rdy   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz_o <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_pr    <= '0;
            r_cnt   <= CNT_W'(DIVIDEND_W - 1);
            r_dbz_o <= 1'b0;
            if (divisor == '0) begin
              r_q     <= QUOT_DBZ;
              r_dbz   <= 1'b1;
              r_wait  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_q     <= '0;
              r_dbz   <= 1'b0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_pr  <= w_pr_next;
          r_q   <= {r_q[DIVIDEND_W-2:0], w_q_bit};
          r_dvd <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // zero divisor lingers one extra cycle before reporting
          if (r_wait) begin
            r_wait <= 1'b0;
          end else begin
            r_quot  <= r_q;
            r_rem   <= r_pr;
            r_dbz_o <= r_dbz;
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == CALC);
  assign rdy         = r_rdy;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz_o;
endmodule
